seg7_scan_driver: RTL and testbench

- Downstream consumer of the display multiplexor's four 4-bit digit values (segment_0..segment_3, hh:mm, segment_3 = tens of hours).
- Time-multiplexes one common-anode 4-digit seven-segment display: rotates a one-hot active-low anode, decodes the selected digit to active-low cathodes, and drives the colon.
- Adds leading-zero blanking and whole-display blinking, used while the alarm time or keypad entry is being edited.

---
 rtl/seg7_scan_driver.sv | 112 +++++++++++
 tb/tb_seg7_scan_driver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Common-anode 4-digit seven-segment scanner: one-hot active-low anode rotation, BCD decode,
// leading-zero blank, whole-display blink and colon; all outputs registered, one-cycle latency.
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_HALF = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] segment_0,
  input  logic [3:0] segment_1,
  input  logic [3:0] segment_2,
  input  logic [3:0] segment_3,
  input  logic       blank_leading,
  input  logic       blink_en,
  input  logic       colon_en,
  output logic [3:0] anode_n,
  output logic [6:0] cathode_n,
  output logic       dp_n
);

  localparam int SW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int RW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROT_LAST  = RW'(BLINK_HALF - 1);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;

  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_idx;
  logic [RW-1:0] r_rot_cnt;
  logic          r_blink_phase;

  logic [3:0] w_digit;
  logic [6:0] w_decoded;
  logic       w_blink_off;
  logic       w_lz_blank;
  logic [3:0] w_anode_n;
  logic [6:0] w_cathode_n;
  logic       w_dp_n;
  logic       w_slot_end;
  logic       w_rot_end;

  always_comb begin
    w_digit = segment_0;
    case (r_idx)
      2'd0: w_digit = segment_0;
      2'd1: w_digit = segment_1;
      2'd2: w_digit = segment_2;
      2'd3: w_digit = segment_3;
      default: w_digit = segment_0;
    endcase
  end

  // Cathode patterns are {g,f,e,d,c,b,a}, active low; codes above 9 show nothing.
  always_comb begin
    w_decoded = SEG_BLANK;
    case (w_digit)
      4'd0: w_decoded = 7'h40;
      4'd1: w_decoded = 7'h79;
      4'd2: w_decoded = 7'h24;
      4'd3: w_decoded = 7'h30;
      4'd4: w_decoded = 7'h19;
      4'd5: w_decoded = 7'h12;
      4'd6: w_decoded = 7'h02;
      4'd7: w_decoded = 7'h78;
      4'd8: w_decoded = 7'h00;
      4'd9: w_decoded = 7'h10;
      default: w_decoded = SEG_BLANK;
    endcase
  end

  assign w_blink_off = blink_en & r_blink_phase;
  assign w_lz_blank  = (r_idx == 2'd3) & blank_leading & (segment_3 == 4'd0);
  assign w_anode_n   = ~(4'b0001 << r_idx);
  assign w_cathode_n = (w_blink_off | w_lz_blank) ? SEG_BLANK : w_decoded;
  assign w_dp_n      = ~(colon_en & (r_idx == 2'd2) & ~w_blink_off);
  assign w_slot_end  = (r_scan_cnt == SCAN_LAST);
  assign w_rot_end   = w_slot_end & (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt    <= '0;
      r_idx         <= '0;
      r_rot_cnt     <= '0;
      r_blink_phase <= 1'b0;
      anode_n       <= 4'hF;
      cathode_n     <= SEG_BLANK;
      dp_n          <= 1'b1;
    end else begin
      anode_n   <= w_anode_n;
      cathode_n <= w_cathode_n;
      dp_n      <= w_dp_n;

      if (w_slot_end) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end

      // Blink phase advances on completed rotations, independent of blink_en.
      if (w_rot_end) begin
        if (r_rot_cnt == ROT_LAST) begin
          r_rot_cnt     <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_rot_cnt <= r_rot_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver with a time-based reference model and literal anchors.
module tb_seg7_scan_driver;

  localparam int SD = 4;
  localparam int BH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] segment_0, segment_1, segment_2, segment_3;
  logic       blank_leading, blink_en, colon_en;
  logic [3:0] anode_n;
  logic [6:0] cathode_n;
  logic       dp_n;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
    .clk(clk), .reset(reset),
    .segment_0(segment_0), .segment_1(segment_1),
    .segment_2(segment_2), .segment_3(segment_3),
    .blank_leading(blank_leading), .blink_en(blink_en), .colon_en(colon_en),
    .anode_n(anode_n), .cathode_n(cathode_n), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: everything follows from n = non-reset edges since the last reset edge.
  logic [6:0] seg_tbl [16];
  initial begin
    seg_tbl[0] = 7'h40; seg_tbl[1] = 7'h79; seg_tbl[2] = 7'h24; seg_tbl[3] = 7'h30;
    seg_tbl[4] = 7'h19; seg_tbl[5] = 7'h12; seg_tbl[6] = 7'h02; seg_tbl[7] = 7'h78;
    seg_tbl[8] = 7'h00; seg_tbl[9] = 7'h10;
    for (int i = 10; i < 16; i++) seg_tbl[i] = 7'h7F;
  end

  int         n = 0;
  bit         valid = 0;
  logic [3:0] e_an;
  logic [6:0] e_ca;
  logic       e_dp;

  always @(posedge clk) begin
    int d, ph;
    logic [3:0] dig;
    logic boff;
    if (reset) begin
      e_an = 4'hF; e_ca = 7'h7F; e_dp = 1'b1; n = 0; valid = 1;
    end else if (valid) begin
      d   = (n / SD) % 4;
      ph  = (n / (4 * SD * BH)) % 2;
      dig = (d == 0) ? segment_0 : (d == 1) ? segment_1 : (d == 2) ? segment_2 : segment_3;
      boff = blink_en && (ph == 1);
      e_an = ~(4'b0001 << d);
      if (boff) e_ca = 7'h7F;
      else if (d == 3 && blank_leading && segment_3 == 4'd0) e_ca = 7'h7F;
      else e_ca = seg_tbl[dig];
      e_dp = !(colon_en && d == 2 && !boff);
      n++;
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("anode_n", 32'(anode_n), 32'(e_an));
      chk("cathode_n", 32'(cathode_n), 32'(e_ca));
      chk("dp_n", 32'(dp_n), 32'(e_dp));
    end
  end

  task automatic goto_edge(input int k);
    int guard = 0;
    while (n != k && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (n != k) chk("goto_edge_timeout", 32'(n), 32'(k));
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, d);
    segment_0 = a; segment_1 = b; segment_2 = c; segment_3 = d;
  endtask

  initial begin
    reset = 1'b1; blank_leading = 1'b0; blink_en = 1'b0; colon_en = 1'b0;
    set_digits(4'd5, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    chk("reset_anode", 32'(anode_n), 32'hF);
    chk("reset_cathode", 32'(cathode_n), 32'h7F);
    chk("reset_dp", 32'(dp_n), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("first_anode", 32'(anode_n), 32'hE);
    chk("first_cathode", 32'(cathode_n), 32'h12);

    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    goto_edge(5);  chk("d1_anode", 32'(anode_n), 32'hD); chk("d1_cath", 32'(cathode_n), 32'h24);
    goto_edge(9);  chk("d2_anode", 32'(anode_n), 32'hB); chk("d2_cath", 32'(cathode_n), 32'h30);
    goto_edge(13); chk("d3_anode", 32'(anode_n), 32'h7); chk("d3_cath", 32'(cathode_n), 32'h19);
    goto_edge(17); chk("wrap_anode", 32'(anode_n), 32'hE); chk("wrap_cath", 32'(cathode_n), 32'h79);

    colon_en = 1'b1;
    set_digits(4'hC, 4'd2, 4'd3, 4'd0);
    blank_leading = 1'b1;
    goto_edge(18); chk("invalid_blank", 32'(cathode_n), 32'h7F); chk("dp_off_d0", 32'(dp_n), 32'h1);
    goto_edge(25); chk("colon_on", 32'(dp_n), 32'h0);
    goto_edge(29); chk("lz_blank", 32'(cathode_n), 32'h7F); chk("lz_anode", 32'(anode_n), 32'h7);
    blank_leading = 1'b0;
    @(negedge clk); chk("lz_off_zero", 32'(cathode_n), 32'h40);

    blink_en = 1'b1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    goto_edge(32); chk("blink_last_on", 32'(cathode_n), 32'h19);
    goto_edge(33); chk("blink_off_cath", 32'(cathode_n), 32'h7F);
    goto_edge(40); chk("blink_off_dp", 32'(dp_n), 32'h1);
    blink_en = 1'b0;
    @(negedge clk); chk("blink_drop", 32'(cathode_n), 32'h30); chk("blink_drop_dp", 32'(dp_n), 32'h0);
    blink_en = 1'b1;
    goto_edge(65); chk("blink_back_on", 32'(cathode_n), 32'h79);

    // Reset during the digit-2 slot, then a full slot at digit 0 and a fresh blink phase.
    goto_edge(74);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_anode", 32'(anode_n), 32'hF);
    chk("midreset_cath", 32'(cathode_n), 32'h7F);
    reset = 1'b0;
    goto_edge(4);  chk("restart_anode", 32'(anode_n), 32'hE);
    goto_edge(5);  chk("restart_next", 32'(anode_n), 32'hD);
    goto_edge(32); chk("restart_phase_on", 32'(cathode_n), 32'h19);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0)
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 2)));
      if ($urandom_range(0, 19) == 0) blank_leading = 1'($urandom);
      if ($urandom_range(0, 19) == 0) colon_en = 1'($urandom);
      if ($urandom_range(0, 29) == 0) blink_en = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 599) == 0);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
